// File: rtl/chan_pkg.sv
// Shared types and helpers for the channel error injector.
// The CHAN_ERR_STATS_EN build of chan_err_injector uses popcount16 for its bit-flip statistics.
package chan_pkg;

   typedef enum logic [1:0] {
      CH_OFF      = 2'd0,
      CH_PERIODIC = 2'd1,
      CH_BURST    = 2'd2,
      CH_RANDOM   = 2'd3
   } chan_mode_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_BURST = 2'd1,
      ST_DONE  = 2'd2
   } chan_state_e;

   // x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per enabled cycle; a zero seed is replaced by 1.
module chan_lfsr
   import chan_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] lfsr
);

   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr <= SEED_NZ;
      end else if (en) begin
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/chan_err_injector.sv
// Channel model: registers each coded symbol and XOR-corrupts it inside an injection window.
// Define CHAN_ERR_STATS_EN to build the corrupted-symbol and flipped-bit counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | inside window, waiting for a periodic/random trigger
// ST_BURST | burst mode, burst_rem more symbols still to corrupt
// ST_DONE  | WIN symbols seen; clean pass-through until reset
module chan_err_injector
   import chan_pkg::*;
#(
   parameter int          SYM_W       = 2,
   parameter int          PERIOD_LOG2 = 4,
   parameter int          BURST_LEN   = 3,
   parameter int          WIN         = 256,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cfg_mode,
   input  logic [SYM_W-1:0] cfg_mask,
   input  logic [7:0]       cfg_thresh,
   input  logic             valid_i,
   input  logic [SYM_W-1:0] sym_i,
   output logic             valid_o,
   output logic [SYM_W-1:0] sym_o,
   output logic [SYM_W-1:0] sym_clean_o,
   output logic             err_o,
   output logic             window_done,
   output logic [31:0]      sym_ct,
   output logic [15:0]      err_sym_ct,
   output logic [15:0]      bad_bit_ct
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   chan_state_e   state, state_nxt;
   logic [BW-1:0] burst_rem, burst_rem_nxt;
   logic          corrupt;
   logic [15:0]   lfsr;
   chan_mode_e    mode;
   logic          in_win, last_sym, trig_p, trig_r;
   logic          unused_lfsr_hi;

   chan_lfsr #(.SEED(SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (valid_i),
      .lfsr (lfsr)
   );

   assign mode           = chan_mode_e'(cfg_mode);
   assign in_win         = sym_ct < 32'(WIN);
   assign last_sym       = sym_ct == 32'(WIN - 1);
   assign trig_p         = (sym_ct[PERIOD_LOG2-1:0] == '1) && in_win;
   assign trig_r         = (lfsr[7:0] < cfg_thresh) && in_win;
   assign unused_lfsr_hi = ^lfsr[15:8];
   assign window_done    = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         burst_rem <= '0;
      end else begin
         state     <= state_nxt;
         burst_rem <= burst_rem_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      burst_rem_nxt = burst_rem;
      corrupt       = 1'b0;
      if (valid_i) begin
         case (state)
            ST_RUN: begin
               if ((mode == CH_PERIODIC && trig_p) || (mode == CH_RANDOM && trig_r)) begin
                  corrupt = 1'b1;
               end
               if (mode == CH_BURST && trig_p) begin
                  corrupt       = 1'b1;
                  burst_rem_nxt = BW'(BURST_LEN - 1);
                  if (BURST_LEN > 1) begin
                     state_nxt = ST_BURST;
                  end
               end
               if (last_sym) begin
                  state_nxt = ST_DONE;
               end
            end
            ST_BURST: begin
               // Leaving burst mode mid-burst abandons the remainder uncorrupted.
               if (mode != CH_BURST) begin
                  burst_rem_nxt = '0;
                  state_nxt     = last_sym ? ST_DONE : ST_RUN;
               end else begin
                  corrupt       = 1'b1;
                  burst_rem_nxt = burst_rem - BW'(1);
                  if (last_sym) begin
                     state_nxt = ST_DONE;
                  end else if (burst_rem == BW'(1)) begin
                     state_nxt = ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               state_nxt = ST_DONE;
            end
            default: begin
               state_nxt = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o     <= 1'b0;
         sym_o       <= '0;
         sym_clean_o <= '0;
         err_o       <= 1'b0;
         sym_ct      <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            sym_clean_o <= sym_i;
            sym_o       <= corrupt ? (sym_i ^ cfg_mask) : sym_i;
            err_o       <= corrupt && (cfg_mask != '0);
            if (sym_ct != '1) begin
               sym_ct <= sym_ct + 32'd1;
            end
         end else begin
            err_o <= 1'b0;
         end
      end
   end

`ifdef CHAN_ERR_STATS_EN
   logic [4:0]  mask_pop;
   logic [16:0] bad_sum;

   assign mask_pop = popcount16(16'(cfg_mask));
   assign bad_sum  = {1'b0, bad_bit_ct} + 17'(mask_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_sym_ct <= '0;
         bad_bit_ct <= '0;
      end else if (valid_i && corrupt && (cfg_mask != '0)) begin
         if (err_sym_ct != '1) begin
            err_sym_ct <= err_sym_ct + 16'd1;
         end
         bad_bit_ct <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
      end
   end
`else
   assign err_sym_ct = '0;
   assign bad_bit_ct = '0;
`endif

endmodule

// File: tb/tb_chan_err_injector.sv
// Scoreboard bench for chan_err_injector: driver queues expected outputs, monitor pops and compares.
module tb_chan_err_injector;

   localparam int WIN = 256;
`ifdef CHAN_ERR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk, rst;
   logic [1:0]  cfg_mode, cfg_mask;
   logic [7:0]  cfg_thresh;
   logic        valid_i;
   logic [1:0]  sym_i;
   logic        valid_o, err_o, window_done;
   logic [1:0]  sym_o, sym_clean_o;
   logic [31:0] sym_ct;
   logic [15:0] err_sym_ct, bad_bit_ct;

   typedef struct packed {
      int         k;
      logic [1:0] sym;
      logic [1:0] clean;
      logic       err;
      logic       wd;
   } exp_t;

   exp_t        q[$];
   exp_t        e_mon;
   logic [1:0]  prev_sym;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] lfsr_ref;
   int          tally;

   chan_err_injector #(
      .SYM_W(2), .PERIOD_LOG2(4), .BURST_LEN(3), .WIN(WIN), .SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
      .cfg_thresh(cfg_thresh), .valid_i(valid_i), .sym_i(sym_i),
      .valid_o(valid_o), .sym_o(sym_o), .sym_clean_o(sym_clean_o),
      .err_o(err_o), .window_done(window_done), .sym_ct(sym_ct),
      .err_sym_ct(err_sym_ct), .bad_bit_ct(bad_bit_ct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] sym_of(input int k);
      return 2'((k * 5) ^ (k >> 2));
   endfunction

   function automatic logic burst_exp(input int k);
      return (k < WIN) && (k >= 15) && ((k % 16) == 15 || (k % 16) == 0 || (k % 16) == 1);
   endfunction

   // Monitor: every output cycle must match the next queued expectation; idle cycles must hold.
   always @(negedge clk) begin
      if (!rst) begin
         prev_sym = sym_o;
      end else begin
         if (valid_o) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: valid_o=1 with empty scoreboard");
            end else begin
               e_mon = q.pop_front();
               if (sym_o !== e_mon.sym || sym_clean_o !== e_mon.clean ||
                   err_o !== e_mon.err || window_done !== e_mon.wd) begin
                  errors++;
                  $display("FAIL sym_k%0d: got sym=%b clean=%b err=%b wd=%b, expected sym=%b clean=%b err=%b wd=%b",
                           e_mon.k, sym_o, sym_clean_o, err_o, window_done,
                           e_mon.sym, e_mon.clean, e_mon.err, e_mon.wd);
               end
            end
         end else begin
            checks++;
            if (sym_o !== prev_sym || err_o !== 1'b0) begin
               errors++;
               $display("FAIL idle_hold: got sym=%b err=%b, expected sym=%b err=0",
                        sym_o, err_o, prev_sym);
            end
         end
         prev_sym = sym_o;
      end
   end

   task automatic send(input logic [1:0] mode, input logic [1:0] mask, input logic [7:0] th,
                       input int k, input logic corrupt);
      exp_t e;
      @(negedge clk);
      cfg_mode   = mode;
      cfg_mask   = mask;
      cfg_thresh = th;
      valid_i    = 1'b1;
      sym_i      = sym_of(k);
      e.k     = k;
      e.clean = sym_of(k);
      e.sym   = corrupt ? (sym_of(k) ^ mask) : sym_of(k);
      e.err   = corrupt && (mask != 2'b00);
      e.wd    = (k >= WIN - 1);
      q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      idle();
      while (q.size() != 0 && n < 10) begin
         idle();
         n++;
      end
      check({name, "_drain"}, q.size(), 0);
   endtask

   task automatic check_counts(input string name, input int syms, input int errs, input int bits);
      check({name, "_sym_ct"}, sym_ct, syms);
      check({name, "_err_sym_ct"}, 32'(err_sym_ct), STATS ? errs : 0);
      check({name, "_bad_bit_ct"}, 32'(bad_bit_ct), STATS ? bits : 0);
   endtask

   // Reset with a valid symbol in flight: it must vanish with no trace.
   task automatic do_reset(input string name);
      @(negedge clk);
      valid_i = 1'b1;
      sym_i   = 2'b11;
      #1 rst = 1'b0;
      #1;
      check({name, "_rst_flags"}, 32'({valid_o, sym_o, sym_clean_o, err_o, window_done}), 0);
      check({name, "_rst_sym_ct"}, sym_ct, 0);
      check({name, "_rst_stats"}, {err_sym_ct, bad_bit_ct}, 0);
      valid_i = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      q.delete();
      lfsr_ref = 16'hACE1;
   endtask

   initial begin
      rst        = 1'b0;
      valid_i    = 1'b0;
      sym_i      = 2'b00;
      cfg_mode   = 2'd0;
      cfg_mask   = 2'b00;
      cfg_thresh = 8'd0;
      #1;
      check("por_flags", 32'({valid_o, sym_o, sym_clean_o, err_o, window_done}), 0);
      check("por_counts", sym_ct | 32'(err_sym_ct) | 32'(bad_bit_ct), 0);
      @(negedge clk);
      #1 rst = 1'b1;

      // periodic, back-to-back
      for (int k = 0; k < 300; k++) send(2'd1, 2'b01, 8'd0, k, (k % 16 == 15) && (k < WIN));
      drain("periodic");
      check_counts("periodic", 300, 16, 16);
      check("periodic_window_done", 32'(window_done), 1);

      // burst, truncated at window edge
      do_reset("burst");
      for (int k = 0; k < 300; k++) send(2'd2, 2'b11, 8'd0, k, burst_exp(k));
      drain("burst");
      check_counts("burst", 300, 46, 92);

      // random with zero threshold never corrupts
      do_reset("rnd0");
      for (int k = 0; k < 256; k++) send(2'd3, 2'b11, 8'd0, k, 1'b0);
      drain("rnd0");
      check_counts("rnd0", 256, 0, 0);
      check("rnd0_window_done", 32'(window_done), 1);

      // gapped periodic: 1 valid, 2 idle
      do_reset("gap");
      for (int k = 0; k < 40; k++) begin
         send(2'd1, 2'b01, 8'd0, k, (k % 16 == 15));
         idle();
         idle();
      end
      drain("gap");
      check_counts("gap", 40, 2, 2);

      // burst aborted at k=16 by mode switch; k=17 must be clean in ST_RUN
      do_reset("abort");
      for (int k = 0; k < 100; k++) begin
         if (k == 16)      send(2'd0, 2'b11, 8'd0, k, 1'b0);
         else if (k == 17) send(2'd2, 2'b11, 8'd0, k, 1'b0);
         else              send(2'd2, 2'b11, 8'd0, k, burst_exp(k));
      end
      drain("abort");
      check_counts("abort", 100, 16, 32);

      // mid-run reset, then random against a reference LFSR from SEED
      do_reset("midrun");
      tally = 0;
      for (int k = 0; k < 300; k++) begin
         logic c;
         c = (lfsr_ref[7:0] < 8'd128) && (k < WIN);
         if (c) tally++;
         send(2'd3, 2'b10, 8'd128, k, c);
         lfsr_ref = {lfsr_ref[14:0], lfsr_ref[15] ^ lfsr_ref[13] ^ lfsr_ref[12] ^ lfsr_ref[10]};
      end
      drain("rnd128");
      check_counts("rnd128", 300, tally, tally);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
